// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider control path and datapath.
// Zero-divisor detection is enabled by defining DIVIDER_ZERO_DETECT_EN.
package divider_pkg;

   localparam int DIV_N_DEFAULT = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_DIVISOR,
      S_ITER,
      S_CAPTURE,
      S_DONE
   } div_state_t;

   // Iteration counter width; a 2-iteration divider still needs one bit.
   function automatic int iter_cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/divider_iter_cnt.sv
// Iteration counter for the divider FSM: clear, enable, and a `last` flag at N-1.
// Holds at N-1 so it can never wrap past the terminal count.
module divider_iter_cnt
   import divider_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = iter_cnt_width(N);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !last) begin
         count <= count + CW'(1);
      end
   end

   assign last = (count == CW'(N - 1));

endmodule

// File: rtl/divider_control.sv
// Sequencing FSM for the restoring divider: operand loads, N iterations, capture, done.
// Define DIVIDER_ZERO_DETECT_EN to short-circuit a zero divisor and raise div_by_zero.
module divider_control
   import divider_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] DataIn,
   output logic         ld_D,
   output logic         ld_d,
   output logic         load_res,
   output logic         clr_a,
   output logic         result_valid,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   div_state_t state;

   logic ld_D_r;
   logic ld_d_r;
   logic load_res_r;
   logic clr_a_r;
   logic result_valid_r;
   logic busy_r;
   logic done_r;

   logic cnt_clr;
   logic cnt_en;
   logic cnt_last;
   logic zero_divisor;

`ifdef DIVIDER_ZERO_DETECT_EN
   logic div_by_zero_r;

   assign zero_divisor = (DataIn == '0);

   // Sticky until the next accepted start; the short-circuit path is the only setter.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_by_zero_r <= 1'b0;
      end else if (state == S_IDLE && start) begin
         div_by_zero_r <= 1'b0;
      end else if (state == S_LOAD_DIVISOR && zero_divisor) begin
         div_by_zero_r <= 1'b1;
      end
   end

   assign div_by_zero = div_by_zero_r;
`else
   logic unused_data_in;

   assign unused_data_in = ^DataIn;
   assign zero_divisor   = 1'b0;
   assign div_by_zero    = 1'b0;
`endif

   assign cnt_clr = (state == S_LOAD_DIVISOR);
   assign cnt_en  = (state == S_ITER);

   divider_iter_cnt #(
      .N (N)
   ) u_iter_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .last  (cnt_last)
   );

   // Outputs are registered against the state being entered, so each strobe
   // lines up with its state without a decode stage after the flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         ld_D_r         <= 1'b0;
         ld_d_r         <= 1'b0;
         load_res_r     <= 1'b0;
         clr_a_r        <= 1'b0;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         ld_D_r         <= 1'b0;
         ld_d_r         <= 1'b0;
         load_res_r     <= 1'b0;
         clr_a_r        <= 1'b0;
         result_valid_r <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_LOAD_DIVISOR;
                  ld_d_r  <= 1'b1;
                  clr_a_r <= 1'b1;
                  busy_r  <= 1'b1;
               end
            end
            S_LOAD_DIVISOR: begin
               busy_r <= 1'b1;
               if (zero_divisor) begin
                  state  <= S_DONE;
                  done_r <= 1'b1;
               end else begin
                  state      <= S_ITER;
                  ld_D_r     <= 1'b1;
                  load_res_r <= 1'b1;
               end
            end
            S_ITER: begin
               busy_r <= 1'b1;
               if (cnt_last) begin
                  state          <= S_CAPTURE;
                  result_valid_r <= 1'b1;
               end else begin
                  ld_D_r     <= 1'b1;
                  load_res_r <= 1'b1;
               end
            end
            S_CAPTURE: begin
               state  <= S_DONE;
               busy_r <= 1'b1;
               done_r <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // The dividend load in IDLE follows start directly so the operand is taken the same cycle.
   assign ld_D         = ld_D_r | ((state == S_IDLE) && start && !reset);
   assign ld_d         = ld_d_r;
   assign load_res     = load_res_r;
   assign clr_a        = clr_a_r;
   assign result_valid = result_valid_r;
   assign busy         = busy_r;
   assign done         = done_r;

endmodule

// File: tb/tb_divider_control.sv
// Scoreboard bench for divider_control with a behavioural restoring-divider datapath.
// Expected strobe timing and Q/R are hand-computed; DIVIDER_ZERO_DETECT_EN selects the zero-divisor outcome.
module tb_divider_control;

   localparam int N = 4;

`ifdef DIVIDER_ZERO_DETECT_EN
   localparam bit ZERO_DETECT = 1'b1;
`else
   localparam bit ZERO_DETECT = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         start;
   logic [N-1:0] DataIn;
   logic         ld_D;
   logic         ld_d;
   logic         load_res;
   logic         clr_a;
   logic         result_valid;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   divider_control #(
      .N (N)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .DataIn       (DataIn),
      .ld_D         (ld_D),
      .ld_d         (ld_d),
      .load_res     (load_res),
      .clr_a        (clr_a),
      .result_valid (result_valid),
      .busy         (busy),
      .done         (done),
      .div_by_zero  (div_by_zero)
   );

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
      int           done_cycle;
   } sb_t;

   sb_t sb_q[$];

   int n_checks;
   int n_fail;
   int cyc;
   int rv_count;
   logic exp_dbz;
   logic [N-1:0] last_q;
   logic [N-1:0] last_r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Restoring-divider datapath driven only by the DUT strobes.
   logic [N-1:0] m_dvd, m_dvs, m_a, m_q, m_r;
   logic [N:0]   sh_a, diff;

   always_comb begin
      sh_a = {m_a, m_dvd[N-1]};
      diff = sh_a - {1'b0, m_dvs};
   end

   always @(posedge clk) begin
      if (clr_a) m_a <= '0;
      if (ld_d) m_dvs <= DataIn;
      if (ld_D) begin
         if (!load_res) begin
            m_dvd <= DataIn;
         end else if (diff[N]) begin
            m_a   <= sh_a[N-1:0];
            m_dvd <= {m_dvd[N-2:0], 1'b0};
         end else begin
            m_a   <= diff[N-1:0];
            m_dvd <= {m_dvd[N-2:0], 1'b1};
         end
      end
      if (result_valid) begin
         m_q <= m_dvd;
         m_r <= m_a;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [6:0] exp_strobe(input int rel, input bit zpath);
      if (rel == 0) return 7'b1000000;
      if (rel == 1) return 7'b0101010;
      if (zpath) return 7'b0000011;
      if (rel <= N + 1) return 7'b1010010;
      if (rel == N + 2) return 7'b0000110;
      return 7'b0000011;
   endfunction

   function automatic logic [7:0] outputs_now();
      return {ld_D, ld_d, load_res, clr_a, result_valid, busy, done, div_by_zero};
   endfunction

   // Monitor: every done pulse must match the oldest outstanding scoreboard entry.
   always @(negedge clk) begin
      if (!reset && result_valid) rv_count++;
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            checkOutput("done_cycle", cyc, e.done_cycle);
            checkOutput("quotient", {28'd0, m_q}, {28'd0, e.q});
            checkOutput("remainder", {28'd0, m_r}, {28'd0, e.r});
            checkOutput("dbz_at_done", {31'd0, div_by_zero}, {31'd0, e.dbz});
         end
      end
   end

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         start  = 1'b0;
         DataIn = 4'h5;
         @(negedge clk);
         checkOutput($sformatf("idle_%0d", i), {24'd0, outputs_now()}, {24'd0, 7'b0, exp_dbz});
      end
   endtask

   // One division; hold keeps start high throughout, poke pulses start mid-ITER,
   // abort asserts reset in cycle 3 and expects IDLE in cycle 4.
   task automatic applyStimulus(input logic [N-1:0] dividend, input logic [N-1:0] divisor,
                                input logic [N-1:0] q, input logic [N-1:0] r,
                                input bit hold, input bit poke, input bit abort);
      bit   zpath;
      int   last_rel;
      int   t0;
      sb_t  e;
      logic [7:0] expv;
      zpath    = ZERO_DETECT && (divisor == '0);
      last_rel = abort ? 4 : (zpath ? 2 : N + 3);
      @(posedge clk);
      #1;
      start  = 1'b1;
      DataIn = dividend;
      t0     = cyc;
      if (!abort) begin
         e.done_cycle = t0 + last_rel;
         e.dbz        = zpath;
         if (zpath) begin
            e.q = last_q;
            e.r = last_r;
         end else begin
            e.q    = q;
            e.r    = r;
            last_q = q;
            last_r = r;
         end
         sb_q.push_back(e);
      end
      for (int rel = 0; rel <= last_rel; rel++) begin
         if (rel > 0) begin
            @(posedge clk);
            #1;
            start  = hold || (poke && rel == 3);
            DataIn = (rel == 1) ? divisor : 4'hA;
            if (abort && rel == 3) reset = 1'b1;
            if (abort && rel == 4) reset = 1'b0;
         end
         if (rel == 1) exp_dbz = 1'b0;
         if (rel == 2 && zpath) exp_dbz = 1'b1;
         if (abort && rel == 4) expv = 8'h00;
         else expv = {exp_strobe(rel, zpath), exp_dbz};
         @(negedge clk);
         checkOutput($sformatf("strobes_%0d/%0d_rel%0d", dividend, divisor, rel),
                     {24'd0, outputs_now()}, {24'd0, expv});
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rv_before;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rv_count = 0;
      exp_dbz  = 1'b0;
      last_q   = '0;
      last_r   = '0;
      reset    = 1'b1;
      start    = 1'b0;
      DataIn   = '0;

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput($sformatf("reset_%0d", i), {24'd0, outputs_now()}, 32'd0);
      end
      start  = 1'b1;
      DataIn = 4'd11;
      @(negedge clk);
      checkOutput("start_during_reset", {24'd0, outputs_now()}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checkOutput("idle_after_reset", {24'd0, outputs_now()}, 32'd0);

      $display("[TB] basic division 11/3");
      applyStimulus(4'd11, 4'd3, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);

      $display("[TB] start pulsed during ITER");
      applyStimulus(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);

      $display("[TB] start held high, back-to-back divisions");
      applyStimulus(4'd13, 4'd4, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'd15, 4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset mid-operation");
      rv_before = rv_count;
      applyStimulus(4'd11, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("no_capture_on_abort", rv_count, rv_before);
      applyStimulus(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);

      $display("[TB] divide by zero 9/0");
      applyStimulus(4'd9, 4'd0, 4'd15, 4'd9, 1'b0, 1'b0, 1'b0);
      idleCycles(3);
      applyStimulus(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0);

      idleCycles(2);
      checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
